// File: rtl/clz_normalizer_pkg.sv
// norm_pkg: shared state encoding and default sizing for the leading-zero normalizer
package norm_pkg;
   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
   localparam int WIDTH_DEF = 32;
   localparam int LOG2W_DEF = $clog2(WIDTH_DEF);
endpackage

// File: rtl/clz_normalizer_if.sv
// clz_normalizer_if: operand/result valid-ready bundle; ctz exists only when NORM_CTZ_EN is defined
interface clz_normalizer_if import norm_pkg::*; #(
   parameter int WIDTH = WIDTH_DEF
);
   localparam int LOG2W = $clog2(WIDTH);
   logic in_valid;
   logic in_ready;
   logic [WIDTH-1:0] in_data;
`ifdef NORM_CTZ_EN
   logic ctz;
`endif
   logic out_valid;
   logic out_ready;
   logic [WIDTH-1:0] out_norm;
   logic [LOG2W:0] out_count;
   logic out_zero;
   modport master (
`ifdef NORM_CTZ_EN
      output ctz,
`endif
      output in_valid, in_data, out_ready,
      input in_ready, out_valid, out_norm, out_count, out_zero
   );
   modport slave (
`ifdef NORM_CTZ_EN
      input ctz,
`endif
      input in_valid, in_data, out_ready,
      output in_ready, out_valid, out_norm, out_count, out_zero
   );
endinterface

// File: rtl/clz_normalizer_bitrev.sv
// norm_bitrev: purely combinational bit reversal of a WIDTH-bit word
module norm_bitrev import norm_pkg::*; #(
   parameter int WIDTH = WIDTH_DEF
) (
   input logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);
   for (genvar i = 0; i < WIDTH; i++) begin : g_rev
      assign q[i] = d[WIDTH-1-i];
   end
endmodule

// File: rtl/clz_normalizer.sv
// clz_normalizer: iterative binary-search leading-zero count and normalize; NORM_CTZ_EN adds trailing-zero mode
module clz_normalizer import norm_pkg::*; #(
   parameter int WIDTH = WIDTH_DEF
) (
   input logic clk,
   input logic rst_n,
   clz_normalizer_if.slave bus
);
   localparam int LOG2W = $clog2(WIDTH);
   state_t state;
   logic [WIDTH-1:0] work, ld_data, nxt_work, nxt_norm;
   logic [LOG2W:0] cnt, nxt_cnt, k;
   logic [LOG2W-1:0] step;
   logic hi_zero;
`ifdef NORM_CTZ_EN
   logic ctz_q;
   logic [WIDTH-1:0] rev_in, rev_work;
   norm_bitrev #(.WIDTH(WIDTH)) u_rev_in (.d(bus.in_data), .q(rev_in));
   norm_bitrev #(.WIDTH(WIDTH)) u_rev_out (.d(nxt_work), .q(rev_work));
   assign ld_data = bus.ctz ? rev_in : bus.in_data;
   assign nxt_norm = ctz_q ? rev_work : nxt_work;
`else
   assign ld_data = bus.in_data;
   assign nxt_norm = nxt_work;
`endif
   // one search probe: drop the top k bits when they are all zero
   always_comb begin
      k = (LOG2W+1)'(1) << step;
      hi_zero = (work >> ((LOG2W+1)'(WIDTH) - k)) == '0;
      nxt_work = hi_zero ? work << k : work;
      nxt_cnt = hi_zero ? cnt + k : cnt;
   end
   // control FSM; results are registered on the final probe so out_valid rises LOG2W edges after accept
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         work <= '0;
         cnt <= '0;
         step <= '0;
`ifdef NORM_CTZ_EN
         ctz_q <= 1'b0;
`endif
         bus.in_ready <= 1'b1;
         bus.out_valid <= 1'b0;
         bus.out_norm <= '0;
         bus.out_count <= '0;
         bus.out_zero <= 1'b0;
      end else begin
         case (state)
            IDLE: if (bus.in_valid) begin
               work <= ld_data;
               cnt <= '0;
               step <= LOG2W'(LOG2W-1);
`ifdef NORM_CTZ_EN
               ctz_q <= bus.ctz;
`endif
               bus.in_ready <= 1'b0;
               state <= SHIFT;
            end
            SHIFT: begin
               work <= nxt_work;
               cnt <= nxt_cnt;
               if (step == '0) begin
                  state <= DONE;
                  bus.out_valid <= 1'b1;
                  bus.out_norm <= nxt_norm;
                  bus.out_zero <= nxt_work == '0;
                  bus.out_count <= (nxt_work == '0) ? (LOG2W+1)'(WIDTH) : nxt_cnt;
               end else step <= step - 1'b1;
            end
            DONE: if (bus.out_ready) begin
               state <= IDLE;
               bus.out_valid <= 1'b0;
               bus.in_ready <= 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_clz_normalizer.sv
// tb_clz_normalizer: directed checks of latency, counts, backpressure, dropped pulses and async reset
module tb_clz_normalizer;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int checks = 0;
   int errors = 0;
   int lat;
   clz_normalizer_if #(.WIDTH(32)) bus ();
   clz_normalizer #(.WIDTH(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [31:0] d);
      bus.in_valid = 1'b1;
      bus.in_data = d;
      tick();
      bus.in_valid = 1'b0;
      lat = 0;
      while (!bus.out_valid && lat < 20) begin
         tick();
         lat++;
      end
   endtask

   task automatic handshake();
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      chk("hs_valid_low", 64'(bus.out_valid), 64'd0);
      chk("hs_ready_high", 64'(bus.in_ready), 64'd1);
   endtask

   initial begin
      bus.in_valid = 1'b0;
      bus.in_data = '0;
      bus.out_ready = 1'b0;
`ifdef NORM_CTZ_EN
      bus.ctz = 1'b0;
`endif
      tick();
      tick();
      chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
      chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
      chk("rst_out_norm", 64'(bus.out_norm), 64'd0);
      chk("rst_out_count", 64'(bus.out_count), 64'd0);
      chk("rst_out_zero", 64'(bus.out_zero), 64'd0);
      rst_n = 1'b1;
      tick();
      send(32'h0000_0001);
      chk("one_latency", 64'(lat), 64'd5);
      chk("one_count", 64'(bus.out_count), 64'd31);
      chk("one_norm", 64'(bus.out_norm), 64'h8000_0000);
      chk("one_zero", 64'(bus.out_zero), 64'd0);
      chk("one_in_ready", 64'(bus.in_ready), 64'd0);
      handshake();
      send(32'h00F0_0000);
      chk("f0_count", 64'(bus.out_count), 64'd8);
      chk("f0_norm", 64'(bus.out_norm), 64'hF000_0000);
      handshake();
      send(32'h8000_0000);
      chk("msb_count", 64'(bus.out_count), 64'd0);
      chk("msb_norm", 64'(bus.out_norm), 64'h8000_0000);
      chk("msb_zero", 64'(bus.out_zero), 64'd0);
      handshake();
      send(32'h0000_0000);
      chk("zero_count", 64'(bus.out_count), 64'd32);
      chk("zero_norm", 64'(bus.out_norm), 64'd0);
      chk("zero_zero", 64'(bus.out_zero), 64'd1);
      handshake();
      bus.in_valid = 1'b1;
      bus.in_data = 32'h1234_5678;
      tick();
      bus.in_valid = 1'b0;
      tick();
      bus.in_valid = 1'b1;
      bus.in_data = 32'hFFFF_FFFF;
      tick();
      chk("bp_shift_in_ready", 64'(bus.in_ready), 64'd0);
      bus.in_valid = 1'b0;
      lat = 2;
      while (!bus.out_valid && lat < 20) begin
         tick();
         lat++;
      end
      chk("bp_latency", 64'(lat), 64'd5);
      bus.in_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("bp_valid", 64'(bus.out_valid), 64'd1);
         chk("bp_count", 64'(bus.out_count), 64'd3);
         chk("bp_norm", 64'(bus.out_norm), 64'h91A2_B3C0);
         chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
      end
      bus.in_valid = 1'b0;
      handshake();
      for (int i = 0; i < 7; i++) tick();
      chk("dropped_pulse", 64'(bus.out_valid), 64'd0);
      chk("idle_after_drop", 64'(bus.in_ready), 64'd1);
      send(32'h0001_0000);
      chk("after_bp_count", 64'(bus.out_count), 64'd15);
      chk("after_bp_norm", 64'(bus.out_norm), 64'h8000_0000);
      handshake();
      bus.in_valid = 1'b1;
      bus.in_data = 32'h0000_0003;
      tick();
      bus.in_valid = 1'b0;
      tick();
      tick();
      rst_n = 1'b0;
      #1;
      chk("abort_out_valid", 64'(bus.out_valid), 64'd0);
      chk("abort_in_ready", 64'(bus.in_ready), 64'd1);
      tick();
      rst_n = 1'b1;
      tick();
      send(32'h0000_FFFF);
      chk("fresh_latency", 64'(lat), 64'd5);
      chk("fresh_count", 64'(bus.out_count), 64'd16);
      chk("fresh_norm", 64'(bus.out_norm), 64'hFFFF_0000);
      handshake();
`ifdef NORM_CTZ_EN
      bus.ctz = 1'b1;
      send(32'h0000_0100);
      chk("ctz_count", 64'(bus.out_count), 64'd8);
      chk("ctz_norm", 64'(bus.out_norm), 64'h0000_0001);
      chk("ctz_zero_flag", 64'(bus.out_zero), 64'd0);
      handshake();
      send(32'h0000_0000);
      chk("ctz0_count", 64'(bus.out_count), 64'd32);
      chk("ctz0_zero", 64'(bus.out_zero), 64'd1);
      chk("ctz0_norm", 64'(bus.out_norm), 64'd0);
      handshake();
      bus.ctz = 1'b0;
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
